// File: rtl/times_table_ctrl.sv
// times_table_ctrl: walks an external multiplier through n*0 .. n*7.
// Each entry is issued, waited on for MUL_LATENCY cycles, and presented
// through a valid/ready handshake. Accepted products go into table_sum.
module times_table_ctrl #(
    parameter int unsigned MUL_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] n,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [2:0] mul_a,
    output logic [2:0] mul_b,
    output logic       mul_enable,
    input  logic [5:0] mul_result,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_index,
    output logic [5:0] out_product,
    output logic [7:0] table_sum
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUTPUT,
        DONE
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(MUL_LATENCY - 1);

    state_t     state;
    logic [2:0] n_q;
    logic [2:0] index;
    logic [1:0] wait_cnt;

    // Sequencer: state, latched operand, index and all registered outputs.
    // Outputs are written on the edge that enters the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            n_q         <= '0;
            index       <= '0;
            wait_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mul_enable  <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            out_valid   <= 1'b0;
            out_index   <= '0;
            out_product <= '0;
            table_sum   <= '0;
        end else if (abort && state != IDLE) begin
            // Abort beats any pending handshake; partial sum and last entry are kept.
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mul_enable <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            out_valid  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        n_q        <= n;
                        index      <= '0;
                        table_sum  <= '0;
                        busy       <= 1'b1;
                        mul_enable <= 1'b1;
                        mul_a      <= n;
                        mul_b      <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_enable <= 1'b0;
                    wait_cnt   <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        out_product <= mul_result;
                        out_index   <= index;
                        out_valid   <= 1'b1;
                        state       <= OUTPUT;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        table_sum <= table_sum + {2'b00, out_product};
                        if (index == 3'd7) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            index      <= index + 3'd1;
                            mul_enable <= 1'b1;
                            mul_a      <= n_q;
                            mul_b      <= index + 3'd1;
                            state      <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    mul_a <= '0;
                    mul_b <= '0;
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    mul_enable <= 1'b0;
                    mul_a      <= '0;
                    mul_b      <= '0;
                    out_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_times_table_ctrl.sv
// Bench for times_table_ctrl: two instances (multiplier latency 1 and 3)
// share the same stimulus, each fed by its own pipelined multiplier model
// and checked every cycle against a table-level behavioural model.
module tb_times_table_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ready = 1'b0;
    logic [2:0] n_in = '0;

    logic [1:0] busy_w, done_w, en_w, ov_w;
    logic [2:0] ma_w [2];
    logic [2:0] mb_w [2];
    logic [2:0] oi_w [2];
    logic [5:0] op_w [2];
    logic [5:0] mres [2];
    logic [7:0] sum_w [2];

    int n_cmp = 0;
    int n_bad = 0;
    int dcnt [2] = '{0, 0};
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    times_table_ctrl #(.MUL_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .start(start), .n(n_in), .abort(abort),
        .busy(busy_w[0]), .done(done_w[0]), .mul_a(ma_w[0]), .mul_b(mb_w[0]),
        .mul_enable(en_w[0]), .mul_result(mres[0]), .out_valid(ov_w[0]),
        .out_ready(ready), .out_index(oi_w[0]), .out_product(op_w[0]),
        .table_sum(sum_w[0])
    );

    times_table_ctrl #(.MUL_LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst), .start(start), .n(n_in), .abort(abort),
        .busy(busy_w[1]), .done(done_w[1]), .mul_a(ma_w[1]), .mul_b(mb_w[1]),
        .mul_enable(en_w[1]), .mul_result(mres[1]), .out_valid(ov_w[1]),
        .out_ready(ready), .out_index(oi_w[1]), .out_product(op_w[1]),
        .table_sum(sum_w[1])
    );

    // Multiplier models: product is only valid exactly LAT cycles after enable;
    // every other cycle the result bus carries random junk.
    logic       pv [2][3];
    logic [5:0] pd [2][3];
    logic [5:0] garb [2];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            pv[i][0] <= en_w[i];
            pd[i][0] <= {3'b000, ma_w[i]} * {3'b000, mb_w[i]};
            pv[i][1] <= pv[i][0];
            pd[i][1] <= pd[i][0];
            pv[i][2] <= pv[i][1];
            pd[i][2] <= pd[i][1];
            garb[i]  <= 6'($urandom);
        end
    end
    assign mres[0] = pv[0][0] ? pd[0][0] : garb[0];
    assign mres[1] = pv[1][2] ? pd[1][2] : garb[1];

    // Inputs as seen by the clock edge, for the model.
    logic       s_rst, s_start, s_abort, s_ready;
    logic [2:0] s_n;
    always @(posedge clk) begin
        s_rst   <= rst;
        s_start <= start;
        s_abort <= abort;
        s_ready <= ready;
        s_n     <= n_in;
    end

    // Behavioural model: phase 0 = computing (cnt cycles since issue),
    // 1 = entry presented, 2 = completion cycle.
    typedef struct {
        bit          act;
        logic [2:0]  nn;
        logic [2:0]  idx;
        int unsigned phase;
        int unsigned cnt;
        logic [5:0]  op;
        logic [2:0]  oi;
        logic [7:0]  sum;
    } mdl_t;
    mdl_t m [2];

    function automatic int unsigned lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i);
        if (s_rst) begin
            m[i].act = 0; m[i].nn = '0; m[i].idx = '0; m[i].phase = 0;
            m[i].cnt = 0; m[i].op = '0; m[i].oi = '0; m[i].sum = '0;
        end else if (!m[i].act) begin
            if (s_start && !s_abort) begin
                m[i].act = 1; m[i].nn = s_n; m[i].idx = '0; m[i].sum = '0;
                m[i].phase = 0; m[i].cnt = 0;
            end
        end else if (s_abort) begin
            m[i].act = 0;
        end else if (m[i].phase == 0) begin
            if (m[i].cnt == lat_of(i)) begin
                m[i].op = 6'(m[i].nn * m[i].idx);
                m[i].oi = m[i].idx;
                m[i].phase = 1;
            end else begin
                m[i].cnt++;
            end
        end else if (m[i].phase == 1) begin
            if (s_ready) begin
                m[i].sum = m[i].sum + 8'(m[i].op);
                if (m[i].idx == 3'd7) m[i].phase = 2;
                else begin
                    m[i].idx = m[i].idx + 3'd1;
                    m[i].phase = 0;
                    m[i].cnt = 0;
                end
            end
        end else begin
            m[i].act = 0;
        end
    endtask

    // Compare process: advance the model and check every output each cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                model_step(i);
                if (chk_en) begin
                    if (done_w[i] === 1'b1) dcnt[i]++;
                    chk($sformatf("busy[%0d]", i), busy_w[i], m[i].act);
                    chk($sformatf("done[%0d]", i), done_w[i], m[i].act && m[i].phase == 2);
                    chk($sformatf("mul_enable[%0d]", i), en_w[i],
                        m[i].act && m[i].phase == 0 && m[i].cnt == 0);
                    chk($sformatf("out_valid[%0d]", i), ov_w[i], m[i].act && m[i].phase == 1);
                    chk($sformatf("out_index[%0d]", i), oi_w[i], m[i].oi);
                    chk($sformatf("out_product[%0d]", i), op_w[i], m[i].op);
                    chk($sformatf("table_sum[%0d]", i), sum_w[i], m[i].sum);
                    if (!m[i].act) begin
                        chk($sformatf("mul_a_idle[%0d]", i), ma_w[i], 0);
                        chk($sformatf("mul_b_idle[%0d]", i), mb_w[i], 0);
                    end else if (m[i].phase == 0) begin
                        chk($sformatf("mul_a[%0d]", i), ma_w[i], m[i].nn);
                        chk($sformatf("mul_b[%0d]", i), mb_w[i], m[i].idx);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input logic [2:0] v);
        start = 1'b1;
        n_in  = v;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_idle(input string nm, input int budget, input bit rnd_ready);
        int c = 0;
        do begin
            if (rnd_ready) ready = 1'($urandom_range(0, 1));
            tick();
            c++;
        end while (busy_w != 2'b00 && c < budget);
        ready = 1'b1;
        chk({nm, "_idle_timeout"}, 32'(busy_w == 2'b00), 1);
    endtask

    int v0, v1, d0, d1, d0n, d1n, c, dsave;

    initial begin
        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", busy_w, 0);
        chk("rst_sum", sum_w[0], 0);
        chk("rst_prod", op_w[0], 0);
        chk("rst_mul_a", ma_w[1], 0);

        // n=3, ready held high: cycle-exact entry and done timing for both latencies
        ready = 1'b1;
        tick();
        pulse(3'd3);
        v0 = 0; v1 = 0; d0 = -1; d1 = -1; d0n = 0; d1n = 0;
        for (int k = 1; k <= 60; k++) begin
            if (ov_w[0]) begin
                chk("s1_slot_l1", k, 3 * (v0 + 1));
                chk("s1_prod_l1", op_w[0], 3 * v0);
                chk("s1_idx_l1", oi_w[0], v0);
                v0++;
            end
            if (ov_w[1]) begin
                chk("s1_slot_l3", k, 5 * (v1 + 1));
                chk("s1_prod_l3", op_w[1], 3 * v1);
                v1++;
            end
            if (done_w[0]) begin d0 = k; d0n++; end
            if (done_w[1]) begin d1 = k; d1n++; end
            tick();
        end
        chk("s1_entries_l1", v0, 8);
        chk("s1_entries_l3", v1, 8);
        chk("s1_done_cyc_l1", d0, 25);
        chk("s1_done_cyc_l3", d1, 41);
        chk("s1_done_cnt_l1", d0n, 1);
        chk("s1_done_cnt_l3", d1n, 1);
        chk("s1_sum_l1", sum_w[0], 84);
        chk("s1_sum_l3", sum_w[1], 84);

        // n=7 with random back-pressure
        dsave = dcnt[0];
        pulse(3'd7);
        run_until_idle("s2", 600, 1'b1);
        tick();
        chk("s2_sum_l1", sum_w[0], 196);
        chk("s2_sum_l3", sum_w[1], 196);
        chk("s2_done_cnt", dcnt[0] - dsave, 1);

        // n=5, start with n=2 while busy must be ignored
        pulse(3'd5);
        c = 0;
        while (!(en_w[0] && mb_w[0] == 3'd3) && c < 100) begin tick(); c++; end
        chk("s3_reach", 32'(c < 100), 1);
        pulse(3'd2);
        run_until_idle("s3", 300, 1'b0);
        chk("s3_sum_l1", sum_w[0], 140);
        chk("s3_sum_l3", sum_w[1], 140);

        // n=4 aborted while entry 4 is presented, then a fresh n=2 table
        dsave = dcnt[0];
        pulse(3'd4);
        c = 0;
        while (!(ov_w[0] && oi_w[0] == 3'd4) && c < 100) begin tick(); c++; end
        chk("s4_reach", 32'(c < 100), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s4_busy", busy_w[0], 0);
        chk("s4_valid", ov_w[0], 0);
        chk("s4_sum", sum_w[0], 24);
        tick();
        tick();
        chk("s4_no_done", dcnt[0] - dsave, 0);
        pulse(3'd2);
        c = 0;
        while (!ov_w[0] && c < 20) begin tick(); c++; end
        chk("s4_restart_idx", oi_w[0], 0);
        run_until_idle("s4", 300, 1'b0);
        chk("s4_sum2", sum_w[0], 56);

        // Reset in WAIT of index 2 (n=6), then an all-zero table
        pulse(3'd6);
        c = 0;
        while (!(en_w[0] && mb_w[0] == 3'd2) && c < 100) begin tick(); c++; end
        chk("s5_reach", 32'(c < 100), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s5_busy", busy_w, 0);
        chk("s5_done", done_w, 0);
        chk("s5_en", en_w, 0);
        chk("s5_valid", ov_w, 0);
        chk("s5_mul_ab", {ma_w[0], mb_w[0]}, 0);
        chk("s5_out", {oi_w[0], op_w[0]}, 0);
        chk("s5_sum", sum_w[0], 0);
        dsave = dcnt[0];
        pulse(3'd0);
        run_until_idle("s5", 300, 1'b0);
        chk("s5_sum0", sum_w[0], 0);
        chk("s5_done_cnt", dcnt[0] - dsave, 1);

        // Random traffic: starts, aborts, resets and back-pressure
        for (int k = 0; k < 3000; k++) begin
            start = ($urandom_range(0, 5) == 0);
            n_in  = 3'($urandom);
            abort = ($urandom_range(0, 149) == 0);
            rst   = ($urandom_range(0, 399) == 0);
            ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        run_until_idle("rnd", 600, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/times_table_ctrl.md
TIMES_TABLE_CTRL -- requirements
Module: times_table_ctrl

Interface
REQ-001 Parameter MUL_LATENCY, default 1: cycles from mul_enable sampled high to mul_result valid; legal range 1..3.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to generate the times table of n; honoured only in IDLE.
REQ-005 n  input  3  table operand; sampled on the accepted start cycle.
REQ-006 abort  input  1  cancel the current table; synchronous.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse after the 8th entry handshake.
REQ-009 mul_a  output  3  multiplier operand a; equals latched n.
REQ-010 mul_b  output  3  multiplier operand b; equals current index.
REQ-011 mul_enable  output  1  multiplier enable; high only in ISSUE.
REQ-012 mul_result  input  6  multiplier product.
REQ-013 out_valid  output  1  table entry available.
REQ-014 out_ready  input  1  consumer accepts the entry.
REQ-015 out_index  output  3  index b of the presented entry.
REQ-016 out_product  output  6  captured n*b.
REQ-017 table_sum  output  8  running sum of accepted products; max 196, no overflow.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, OUTPUT, DONE.
REQ-019 IDLE: start=1 SHALL latch n, clear the index to 0, clear table_sum to 0, and go to ISSUE; start=0 stays in IDLE.
REQ-020 ISSUE: mul_enable=1 for exactly one cycle with mul_a=n and mul_b=index; next state WAIT.
REQ-021 WAIT: mul_enable=0 and mul_a/mul_b held; after exactly MUL_LATENCY cycles, mul_result SHALL be captured into out_product on the last WAIT edge, out_index=index; next state OUTPUT.
REQ-022 OUTPUT: out_valid=1; out_product and out_index SHALL stay stable until out_valid&&out_ready.
REQ-023 On an OUTPUT handshake: table_sum += out_product; if index==7 go to DONE, else index+1 and go to ISSUE.
REQ-024 DONE: done=1 for one cycle, busy=1, table_sum final; next state IDLE.
REQ-025 Per-entry cost with out_ready held high: MUL_LATENCY+2 cycles; with MUL_LATENCY=1 and start high in cycle 0, the entries appear in cycles 3,6,...,24 and done is high in cycle 25.
REQ-026 start while busy SHALL be ignored, with no effect on n, index, or sum.
REQ-027 abort in any non-IDLE state SHALL return to IDLE on the next edge, with out_valid=0, mul_enable=0, no done pulse, and table_sum held at its partial value.
REQ-028 abort in IDLE SHALL be ignored; abort and start together in IDLE give abort priority (stay IDLE).
REQ-029 Index wrap 7->0 SHALL never occur; completion goes to DONE.
REQ-030 In IDLE, out_valid=0, mul_enable=0, mul_a/mul_b=0, and out_product/out_index/table_sum hold their last values.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE and set busy=0, done=0, mul_enable=0, mul_a=0, mul_b=0, out_valid=0, out_index=0, out_product=0, table_sum=0, index=0, latched n=0.
REQ-032 rst SHALL override start and abort, and SHALL be effective mid-table with no done pulse.

Verification
REQ-033 n=3 with out_ready=1, start pulsed in cycle 0 -> products 0,3,6,9,12,15,18,21 at indices 0..7 in cycles 3,6,...,24; done in cycle 25; table_sum=84.
REQ-034 n=7 with out_ready toggled pseudo-randomly -> each entry held stable while stalled; products 0..49 in steps of 7; table_sum=196; exactly one done.
REQ-035 n=5, start re-pulsed with n=2 during index 3 -> table continues as n=5, table_sum=140.
REQ-036 n=4 with abort during OUTPUT of index 4 -> IDLE next cycle, no done, table_sum=24; then start with n=2 -> indices restart at 0, table_sum=56.
REQ-037 rst asserted in WAIT of index 2 (n=6) -> all outputs match REQ-031 the next cycle; then n=0 table -> all products 0, table_sum=0, done pulsed.
REQ-038 MUL_LATENCY=3 with n=3 -> WAIT lasts 3 cycles, 5 cycles per entry, done in cycle 41, table_sum=84.
